ddr_wr_cmd_gen: RTL and testbench
=================================

// Module: ddr_wr_cmd_gen
// PURPOSE
// - Downstream of the PE-to-DDR config stage: consumes one DDR write job (start addr, row burst, row step, row count).
// - Splits the job into AXI4 write-address commands:
//   - each command is at most MAX_LEN beats;
//   - no command crosses a 4 KB boundary;
//   - at most OUTSTANDING commands are in flight.
// - Counts B responses and pulses done when the whole job has been acknowledged.
// - The write-data path is separate; this block carries addresses only.
// PARAMETERS
// DDR_ADDR_W   32  DDR byte-address width
// BURST_W      16  width of burst / burst_num fields
// BUS_BYTES    32  bytes per AXI data beat (256-bit bus); power of 2
// MAX_LEN      16  max beats per AXI command (1..256)
// OUTSTANDING   8  max AW commands awaiting B response
// PORTS
// clk         in   1           clock; all logic on rising edge
// rst_n       in   1           async active-low reset
// start       in   1           1-cycle job request; only accepted in IDLE
// st_addr     in   DDR_ADDR_W  byte address of row 0; BUS_BYTES aligned
// burst       in   BURST_W     bytes per row; multiple of BUS_BYTES
// step        in   DDR_ADDR_W  byte stride between row start addresses
// burst_num   in   BURST_W     rows minus 1 (0 = one row)
// busy        out  1           high from accepted start until done cycle inclusive
// done        out  1           1-cycle pulse when all B responses received
// err         out  1           sticky: any bresp!=OKAY in current job
// m_awaddr    out  DDR_ADDR_W  AXI AW address
// m_awlen     out  8           AXI AW beats-1
// m_awsize    out  3           constant log2(BUS_BYTES)
// m_awburst   out  2           constant 2'b01 (INCR)
// m_awvalid   out  1           AXI AW valid
// m_awready   in   1           AXI AW ready
// m_bvalid    in   1           AXI B valid
// m_bresp     in   2           AXI B response
// m_bready    out  1           AXI B ready
// BEHAVIOUR
// - Reset (async, rst_n=0):
//   - state=IDLE;
//   - busy, done, err, m_awvalid, m_awaddr, m_awlen, m_bready all 0;
//   - all counters 0.
//   - Any job in progress is abandoned; there is no recovery of in-flight commands.
// - IDLE: start=1 latches st_addr, burst, step, burst_num.
//   - Sets row_base=addr=st_addr, beats_left=burst/BUS_BYTES, row=0, err=0, busy=1.
//   - Goes to CALC.
//   - start is ignored while busy.
// - CALC (1 cycle), computing len:
//   - If beats_left==0 (burst<BUS_BYTES): row is skipped (advance-row rule applied); no AW is issued for it.
//   - Otherwise len = min(beats_left, MAX_LEN, (4096-addr[11:0])/BUS_BYTES).
//   - Registers m_awaddr=addr and m_awlen=len-1, then goes to ISSUE.
// - ISSUE:
//   - m_awvalid=1 only while outstanding<OUTSTANDING.
//   - Once m_awvalid is asserted, m_awaddr/m_awlen/m_awvalid are held until m_awready.
//   - On AW handshake: addr+=len*BUS_BYTES, beats_left-=len, outstanding++, m_awvalid=0 next cycle.
//   - If beats_left becomes 0, apply the advance-row rule; else go to CALC.
// - Advance-row rule:
//   - If row==burst_num, go to WAIT_B.
//   - Else row++, row_base+=step, addr=row_base+step, beats_left=burst/BUS_BYTES, go to CALC.
// - First AW: m_awvalid is high 2 cycles after the start cycle (start@0, CALC@1, ISSUE@2).
// - Outstanding counter (0..OUTSTANDING):
//   - +1 on AW handshake, -1 on B handshake.
//   - Both in the same cycle: unchanged.
// - m_bready:
//   - =1 whenever outstanding>0; =0 otherwise.
//   - A stray m_bvalid while outstanding==0 is not accepted.
// - err: set on any accepted B with m_bresp!=2'b00; holds until the next accepted start.
// - WAIT_B: when outstanding==0 (including the cycle its last B is accepted), go to DONE.
// - DONE: done=1 for exactly 1 cycle, busy still 1; next cycle IDLE with busy=0. err is valid in the done cycle.
// - Arithmetic: address math is modulo 2^DDR_ADDR_W; wrap at the top of the address space is not flagged.
// TESTING
// 1. st_addr=0x1000, burst=256, step=0x400, burst_num=2, awready/bvalid prompt
//    -> AW (0x1000,len7), (0x1400,len7), (0x1800,len7); done 1 cycle after 3rd B.
// 2. st_addr=0, burst=1024, burst_num=0 -> AW (0x000,len15), (0x200,len15); done after 2 B.
// 3. st_addr=0x0FC0, burst=256, burst_num=0 -> AW (0x0FC0,len1), (0x1000,len5); no 4 KB crossing.
// 4. awready=0 for 10 cycles -> awaddr/awlen/awvalid stable.
//    Hold bvalid=0 with burst=512, burst_num=15 -> awvalid low after 8 AWs until 1st B accepted.
// 5. bresp=2'b10 on 2nd of 3 B -> err=1 in the done cycle; next start clears err.
//    Start pulsed while busy -> ignored, single done.
// 6. rst_n=0 while in ISSUE -> awvalid, busy, done drop same cycle.
//    After release, test-1 job completes correctly; burst=0, burst_num=0 -> no AW, done at cycle 3.

Source files
------------

// File: rtl/ddr_wr_cmd_gen.sv
// ddr_wr_cmd_gen: splits one strided DDR write job into AXI4 AW commands.
// Each command is capped by MAX_LEN beats and by the next 4 KB boundary.
// The number of commands in flight is bounded by OUTSTANDING. B responses
// are counted, and done pulses once the whole job has been acknowledged.
module ddr_wr_cmd_gen #(
  parameter int DDR_ADDR_W  = 32,
  parameter int BURST_W     = 16,
  parameter int BUS_BYTES   = 32,
  parameter int MAX_LEN     = 16,
  parameter int OUTSTANDING = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DDR_ADDR_W-1:0] st_addr,
  input  logic [BURST_W-1:0]    burst,
  input  logic [DDR_ADDR_W-1:0] step,
  input  logic [BURST_W-1:0]    burst_num,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DDR_ADDR_W-1:0] m_awaddr,
  output logic [7:0]            m_awlen,
  output logic [2:0]            m_awsize,
  output logic [1:0]            m_awburst,
  output logic                  m_awvalid,
  input  logic                  m_awready,
  input  logic                  m_bvalid,
  input  logic [1:0]            m_bresp,
  output logic                  m_bready
);

  localparam int BEAT_SH = $clog2(BUS_BYTES);
  localparam int OUT_W   = $clog2(OUTSTANDING + 1);

  typedef enum logic [2:0] {IDLE, CALC, ISSUE, WAIT_B, DONE} state_t;
  state_t state, state_nxt;

  logic [DDR_ADDR_W-1:0] addr, row_base, step_r, len_bytes;
  logic [BURST_W-1:0]    row_beats_r, num_r, row, beats_left;
  logic [8:0]            len, len_calc;
  logic [OUT_W-1:0]      outstanding;
  logic                  aw_hs, b_hs, last_row, row_empty, row_fin;

  // Beats for the next command: limited by what is left in the row,
  // by MAX_LEN, and by the distance to the next 4 KB page.
  function automatic logic [8:0] calc_len(input logic [BURST_W-1:0] beats,
                                          input logic [11:0]        lo);
    logic [12:0] room, cap;
    logic [31:0] beats32, cap32;
    room    = (13'h1000 - {1'b0, lo}) >> BEAT_SH;
    cap     = (room < 13'(MAX_LEN)) ? room : 13'(MAX_LEN);
    beats32 = 32'(beats);
    cap32   = 32'(cap);
    return (beats32 < cap32) ? 9'(beats32) : 9'(cap32);
  endfunction

  assign len_calc  = calc_len(beats_left, addr[11:0]);
  assign len_bytes = DDR_ADDR_W'(len) << BEAT_SH;
  assign last_row  = (row == num_r);
  assign row_empty = (beats_left == '0);
  assign row_fin   = (beats_left == BURST_W'(len));

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign m_awsize  = 3'(BEAT_SH);
  assign m_awburst = 2'b01;
  assign m_awvalid = (state == ISSUE) && (outstanding < OUT_W'(OUTSTANDING));
  assign m_bready  = (outstanding != '0);
  assign aw_hs     = m_awvalid && m_awready;
  assign b_hs      = m_bvalid && m_bready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; empty rows and finished rows both take the advance-row path.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (start) state_nxt = CALC;
      CALC: begin
        if (row_empty) state_nxt = last_row ? WAIT_B : CALC;
        else           state_nxt = ISSUE;
      end
      ISSUE: begin
        if (aw_hs) begin
          if (row_fin) state_nxt = last_row ? WAIT_B : CALC;
          else         state_nxt = CALC;
        end
      end
      WAIT_B: begin
        if (outstanding == '0 || (outstanding == OUT_W'(1) && b_hs)) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job parameters, address walk and the AW command registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr        <= '0;
      row_base    <= '0;
      step_r      <= '0;
      row_beats_r <= '0;
      num_r       <= '0;
      row         <= '0;
      beats_left  <= '0;
      len         <= '0;
      m_awaddr    <= '0;
      m_awlen     <= '0;
      err         <= 1'b0;
    end else begin
      if (b_hs && (m_bresp != 2'b00)) err <= 1'b1;
      case (state)
        IDLE: begin
          if (start) begin
            addr        <= st_addr;
            row_base    <= st_addr;
            step_r      <= step;
            row_beats_r <= burst >> BEAT_SH;
            beats_left  <= burst >> BEAT_SH;
            num_r       <= burst_num;
            row         <= '0;
            err         <= 1'b0;
          end
        end
        CALC: begin
          if (row_empty) begin
            if (!last_row) begin
              row        <= row + BURST_W'(1);
              row_base   <= row_base + step_r;
              addr       <= row_base + step_r;
              beats_left <= row_beats_r;
            end
          end else begin
            len      <= len_calc;
            m_awaddr <= addr;
            m_awlen  <= 8'(len_calc - 9'd1);
          end
        end
        ISSUE: begin
          if (aw_hs) begin
            addr       <= addr + len_bytes;
            beats_left <= beats_left - BURST_W'(len);
            if (row_fin && !last_row) begin
              row        <= row + BURST_W'(1);
              row_base   <= row_base + step_r;
              addr       <= row_base + step_r;
              beats_left <= row_beats_r;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Commands awaiting a B response; simultaneous AW and B handshakes cancel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({aw_hs, b_hs})
        2'b10:   outstanding <= outstanding + OUT_W'(1);
        2'b01:   outstanding <= outstanding - OUT_W'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_wr_cmd_gen.sv
// Scoreboard bench for ddr_wr_cmd_gen: expected AW commands and per-job err
// values are queued when each job is issued; a monitor pops them on every
// AW handshake and on every done pulse. A B responder answers each AW.
`timescale 1ns/1ps
module tb_ddr_wr_cmd_gen;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [31:0] st_addr = '0, step = '0;
  logic [15:0] burst = '0, burst_num = '0;
  logic        busy, done, err;
  logic [31:0] m_awaddr;
  logic [7:0]  m_awlen;
  logic [2:0]  m_awsize;
  logic [1:0]  m_awburst;
  logic        m_awvalid, m_bready;
  logic        m_awready = 1'b0, m_bvalid = 1'b0;
  logic [1:0]  m_bresp = 2'b00;

  ddr_wr_cmd_gen dut (
    .clk(clk), .rst_n(rst_n), .start(start), .st_addr(st_addr), .burst(burst),
    .step(step), .burst_num(burst_num), .busy(busy), .done(done), .err(err),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_bvalid(m_bvalid), .m_bresp(m_bresp), .m_bready(m_bready)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [31:0] addr; logic [7:0] len; } aw_t;
  aw_t  exp_aw[$];
  logic exp_err[$];
  aw_t  mon_e;
  logic mon_err;

  int vectors = 0, miscompares = 0;
  int cyc = 0, start_cyc = 0, done_cyc = 0, last_b_cyc = 0;
  int aw_count = 0, done_count = 0;
  int pend = 0, bidx = 0, bad_idx = -1;
  logic b_en = 1'b1, aw_f = 1'b0, b_f = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  task automatic push_aw(input logic [31:0] a, input logic [7:0] l);
    aw_t e;
    e.addr = a;
    e.len  = l;
    exp_aw.push_back(e);
  endtask

  // Drives a one-cycle start; returns at cycle 1 (+1 ns after the edge).
  task automatic job(input logic [31:0] a, input logic [15:0] b,
                     input logic [31:0] s, input logic [15:0] n);
    @(posedge clk); #1;
    st_addr = a; burst = b; step = s; burst_num = n; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Waits (bounded) for done; rel is the done cycle relative to the start cycle.
  task automatic wait_done(input string name, output int rel);
    rel = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done) begin
        rel = cyc - start_cyc;
        done_cyc = cyc;
        break;
      end
    end
    if (rel < 0) chk({name, "_done_timeout"}, 64'(0), 64'(1));
    @(negedge clk);
    chk({name, "_done_pulse_width"}, 64'(done), 64'(0));
    chk({name, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  task automatic wait_aw(input int n);
    for (int i = 0; i < 500 && aw_count < n; i++) @(negedge clk);
    if (aw_count < n) chk("aw_count_timeout", 64'(aw_count), 64'(n));
  endtask

  // Scoreboard monitor: compares every AW handshake and every done pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_awvalid && m_awready) begin
        aw_count++;
        chk("aw_size", 64'(m_awsize), 64'(5));
        chk("aw_burst", 64'(m_awburst), 64'(1));
        if (exp_aw.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL aw_unexpected: got addr %0h len %0d, none expected", m_awaddr, m_awlen);
        end else begin
          mon_e = exp_aw.pop_front();
          chk("aw_addr", 64'(m_awaddr), 64'(mon_e.addr));
          chk("aw_len", 64'(m_awlen), 64'(mon_e.len));
        end
      end
      if (done) begin
        done_count++;
        if (exp_err.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL done_unexpected: got done=1, expected no done");
        end else begin
          mon_err = exp_err.pop_front();
          chk("done_err", 64'(err), 64'(mon_err));
        end
      end
    end
  end

  // B responder: one response per accepted AW, bad response on index bad_idx.
  always begin
    @(negedge clk);
    aw_f = m_awvalid && m_awready;
    b_f  = m_bvalid && m_bready;
    if (b_f) last_b_cyc = cyc;
    if (start && !busy) bidx = 0;
    @(posedge clk); #1;
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (aw_f) pend++;
      if (b_f) begin pend--; bidx++; end
    end
    m_bvalid = b_en && (pend > 0) && rst_n;
    m_bresp  = (bidx == bad_idx) ? 2'b10 : 2'b00;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rel;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic stable, seen;
    int   dc;

    // Reset state
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    chk("rst_awvalid", 64'(m_awvalid), 64'(0));
    chk("rst_awaddr", 64'(m_awaddr), 64'(0));
    chk("rst_awlen", 64'(m_awlen), 64'(0));
    chk("rst_bready", 64'(m_bready), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1; m_awready = 1'b1;

    // Test 1: three rows of 8 beats
    push_aw(32'h1000, 8'd7); push_aw(32'h1400, 8'd7); push_aw(32'h1800, 8'd7);
    exp_err.push_back(1'b0);
    job(32'h1000, 16'd256, 32'h400, 16'd2);
    @(negedge clk);
    chk("t1_busy_c1", 64'(busy), 64'(1));
    chk("t1_awvalid_c1", 64'(m_awvalid), 64'(0));
    @(negedge clk);
    chk("t1_awvalid_c2", 64'(m_awvalid), 64'(1));
    wait_done("t1", rel);
    chk("t1_done_after_last_b", 64'(done_cyc), 64'(last_b_cyc + 1));
    chk("t1_bready_idle", 64'(m_bready), 64'(0));

    // Test 2: 32 beats split by MAX_LEN
    push_aw(32'h0000, 8'd15); push_aw(32'h0200, 8'd15);
    exp_err.push_back(1'b0);
    job(32'h0, 16'd1024, 32'h0, 16'd0);
    wait_done("t2", rel);

    // Test 3: split at the 4 KB boundary
    push_aw(32'h0FC0, 8'd1); push_aw(32'h1000, 8'd5);
    exp_err.push_back(1'b0);
    job(32'h0FC0, 16'd256, 32'h0, 16'd0);
    wait_done("t3", rel);

    // Test 4a: AW held stable while awready is low
    m_awready = 1'b0;
    push_aw(32'h0000, 8'd15); push_aw(32'h0200, 8'd15);
    exp_err.push_back(1'b0);
    job(32'h0, 16'd1024, 32'h0, 16'd0);
    @(negedge clk); @(negedge clk);
    chk("t4a_awvalid", 64'(m_awvalid), 64'(1));
    a0 = m_awaddr; l0 = m_awlen; stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (!(m_awvalid && m_awaddr == a0 && m_awlen == l0)) stable = 1'b0;
    end
    chk("t4a_stable", 64'(stable), 64'(1));
    @(posedge clk); #1;
    m_awready = 1'b1;
    wait_done("t4a", rel);

    // Test 4b: outstanding limit with B withheld
    b_en = 1'b0;
    aw_count = 0;
    for (int i = 0; i < 16; i++) push_aw(32'(i) * 32'h200, 8'd15);
    exp_err.push_back(1'b0);
    job(32'h0, 16'd512, 32'h200, 16'd15);
    wait_aw(8);
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (m_awvalid) seen = 1'b1;
    end
    chk("t4b_awvalid_blocked", 64'(seen), 64'(0));
    chk("t4b_aw_count_held", 64'(aw_count), 64'(8));
    b_en = 1'b1;
    wait_done("t4b", rel);
    chk("t4b_aw_total", 64'(aw_count), 64'(16));

    // Test 5: error on 2nd B, ignored start while busy, err cleared by next start
    bad_idx = 1;
    push_aw(32'h1000, 8'd7); push_aw(32'h1400, 8'd7); push_aw(32'h1800, 8'd7);
    exp_err.push_back(1'b1);
    dc = done_count;
    job(32'h1000, 16'd256, 32'h400, 16'd2);
    @(posedge clk); #1;
    st_addr = 32'h8000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("t5", rel);
    repeat (10) @(negedge clk);
    chk("t5_single_done", 64'(done_count - dc), 64'(1));
    chk("t5_err_sticky", 64'(err), 64'(1));
    bad_idx = -1;
    push_aw(32'h0000, 8'd15); push_aw(32'h0200, 8'd15);
    exp_err.push_back(1'b0);
    job(32'h0, 16'd1024, 32'h0, 16'd0);
    @(negedge clk);
    chk("t5_err_cleared", 64'(err), 64'(0));
    wait_done("t5b", rel);

    // Test 6: reset during ISSUE, then a clean job and an empty job
    m_awready = 1'b0;
    job(32'h1000, 16'd256, 32'h400, 16'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("t6_awvalid_pre", 64'(m_awvalid), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("t6_rst_awvalid", 64'(m_awvalid), 64'(0));
    chk("t6_rst_busy", 64'(busy), 64'(0));
    chk("t6_rst_done", 64'(done), 64'(0));
    chk("t6_rst_bready", 64'(m_bready), 64'(0));
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1; m_awready = 1'b1;
    push_aw(32'h1000, 8'd7); push_aw(32'h1400, 8'd7); push_aw(32'h1800, 8'd7);
    exp_err.push_back(1'b0);
    job(32'h1000, 16'd256, 32'h400, 16'd2);
    wait_done("t6", rel);
    exp_err.push_back(1'b0);
    job(32'h0, 16'd0, 32'h0, 16'd0);
    wait_done("t6_empty", rel);
    chk("t6_empty_done_cycle", 64'(rel), 64'(3));

    repeat (5) @(negedge clk);
    chk("aw_queue_drained", 64'(exp_aw.size()), 64'(0));
    chk("err_queue_drained", 64'(exp_err.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
